// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared state encoding, default opcodes and result byte order
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_RUN,
    ST_WAIT_RES,
    ST_SEND_LO,
    ST_GAP,
    ST_SEND_HI,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_FULL_DEF  = 8'hCC;
  localparam logic [7:0] CMD_REUSE_DEF = 8'hDD;

  localparam logic BYTE_LO = 1'b0;
  localparam logic BYTE_HI = 1'b1;

  function automatic logic [7:0] res_byte(input logic [15:0] res, input logic idx);
    return idx ? res[15:8] : res[7:0];
  endfunction

  // States in which an arriving RX byte is an overrun
  function automatic logic in_exec(input state_t s);
    return s inside {ST_RUN, ST_WAIT_RES, ST_SEND_LO, ST_GAP, ST_SEND_HI, ST_DONE};
  endfunction

endpackage

// File: rtl/alu_timeout_cnt.sv
// rtl/alu_timeout_cnt.sv - clearable up-counter flagging the last permitted wait cycle
module alu_timeout_cnt #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [7:0] count;

  // term marks the cycle whose increment would reach TIMEOUT
  assign term = (count == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 8'd0;
    end else if (inc && !term) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - UART command-frame sequencer driving the ALU and returning its result
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int         OP_WIDTH  = 8,
  parameter int         RES_WIDTH = 2 * OP_WIDTH,
  parameter int         TIMEOUT   = 8,
  parameter logic [7:0] CMD_FULL  = CMD_FULL_DEF,
  parameter logic [7:0] CMD_REUSE = CMD_REUSE_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic [OP_WIDTH-1:0]  ALU_A,
  output logic [OP_WIDTH-1:0]  ALU_B,
  output logic [3:0]           ALU_FUN,
  output logic                 ALU_EN,
  input  logic [RES_WIDTH-1:0] ALU_OUT,
  input  logic                 OUT_VALID,
  output logic [7:0]           TX_P_DATA,
  output logic                 TX_D_VLD,
  input  logic                 TX_BUSY,
  output logic                 BUSY,
  output logic                 CMD_ERR
);

  state_t               state;
  logic [RES_WIDTH-1:0] res;
  logic                 cnt_term;

  alu_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk  (CLK),
    .rst  (RST),
    .clr  (state == ST_RUN),
    .inc  ((state == ST_WAIT_RES) && !OUT_VALID),
    .term (cnt_term)
  );

  assign BUSY = (state != ST_IDLE);

  // Transmit request is gated combinationally so it can never coincide with TX_BUSY
  always_comb begin
    TX_D_VLD  = 1'b0;
    TX_P_DATA = 8'h00;
    if (state == ST_SEND_LO) begin
      TX_P_DATA = res_byte(res, BYTE_LO);
      TX_D_VLD  = !TX_BUSY;
    end else if (state == ST_SEND_HI) begin
      TX_P_DATA = res_byte(res, BYTE_HI);
      TX_D_VLD  = !TX_BUSY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_FUN <= 4'h0;
      ALU_EN  <= 1'b0;
      CMD_ERR <= 1'b0;
      res     <= '0;
    end else begin
      ALU_EN  <= 1'b0;
      CMD_ERR <= 1'b0;
      case (state)
        ST_IDLE: if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_FULL)       state <= ST_GET_A;
          else if (RX_P_DATA == CMD_REUSE) state <= ST_GET_FUN;
          else                             CMD_ERR <= 1'b1;
        end
        ST_GET_A: if (RX_D_VLD) begin
          ALU_A <= RX_P_DATA[OP_WIDTH-1:0];
          state <= ST_GET_B;
        end
        ST_GET_B: if (RX_D_VLD) begin
          ALU_B <= RX_P_DATA[OP_WIDTH-1:0];
          state <= ST_GET_FUN;
        end
        ST_GET_FUN: if (RX_D_VLD) begin
          if (RX_P_DATA[7:4] != 4'h0) begin
            CMD_ERR <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            ALU_FUN <= RX_P_DATA[3:0];
            ALU_EN  <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: state <= ST_WAIT_RES;
        ST_WAIT_RES: begin
          if (OUT_VALID) begin
            res   <= ALU_OUT;
            state <= ST_SEND_LO;
          end else if (cnt_term) begin
            CMD_ERR <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_SEND_LO: if (!TX_BUSY) state <= ST_GAP;
        ST_GAP:     state <= ST_SEND_HI;
        ST_SEND_HI: if (!TX_BUSY) state <= ST_DONE;
        ST_DONE:    state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
      if (RX_D_VLD && in_exec(state)) CMD_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - self-checking bench for alu_cmd_ctrl with ALU and UART TX models
module tb_alu_cmd_ctrl;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        OUT_VALID = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY = 1'b0;
  logic        BUSY;
  logic        CMD_ERR;

  alu_cmd_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int cyc = 0;

  // environment knobs
  int          alu_lat = 1;
  bit          alu_force = 0;
  logic [15:0] alu_force_val = 16'h0;
  int          tx_len = 2;
  bit          force_busy = 0;

  // environment state
  bit          alu_pend = 0;
  int          alu_wait = 0;
  logic [15:0] alu_res = 16'h0;
  int          tx_cnt = 0;
  bit          tx_seen = 0;

  // observations
  int         en_cnt = 0, err_cnt = 0, en_cyc = -1, tx_first_cyc = -1, last_rx_cyc = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:  return 16'(a) + 16'(b);
      4'd1:  return 16'(a) - 16'(b);
      4'd2:  return 16'(a) * 16'(b);
      4'd3:  return (b == 0) ? 16'h0 : 16'(a / b);
      4'd4:  return {8'h0, a & b};
      4'd5:  return {8'h0, a | b};
      4'd6:  return {8'h0, ~(a & b)};
      4'd7:  return {8'h0, ~(a | b)};
      4'd8:  return {8'h0, a ^ b};
      4'd9:  return {8'h0, ~(a ^ b)};
      4'd10: return {15'h0, a == b};
      4'd11: return {15'h0, a > b};
      4'd12: return {15'h0, a < b};
      4'd13: return {8'h0, a >> 1};
      4'd14: return 16'(a) << 1;
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // ALU with configurable latency and a transmitter that goes busy the cycle after a request
  always @(posedge clk) begin
    #1;
    OUT_VALID = 1'b0;
    if (alu_pend) begin
      alu_wait--;
      if (alu_wait == 0) begin
        OUT_VALID = 1'b1;
        ALU_OUT   = alu_res;
        alu_pend  = 0;
      end
    end
    if (ALU_EN) begin
      alu_pend = 1;
      alu_wait = alu_lat;
      alu_res  = alu_force ? alu_force_val : ref_alu(ALU_A, ALU_B, ALU_FUN);
    end
    if (tx_seen) tx_cnt = tx_len;
    else if (tx_cnt > 0) tx_cnt--;
    TX_BUSY = force_busy || (tx_cnt > 0);
  end

  always @(negedge clk) begin
    tx_seen = TX_D_VLD;
    if (!RST) begin
      if (ALU_EN) begin en_cnt++; en_cyc = cyc; end
      if (CMD_ERR) err_cnt++;
      if (TX_D_VLD) begin
        check("tx_vld_while_busy", TX_BUSY, 0);
        if (tx_first_cyc < 0) tx_first_cyc = cyc;
        tx_q.push_back(TX_P_DATA);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA   = b;
    RX_D_VLD    = 1'b1;
    last_rx_cyc = cyc;
    tick();
    RX_D_VLD    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 300) begin tick(); n++; end
    check({name, "_idle"}, BUSY, 0);
    repeat (3) tick();
  endtask

  task automatic clear_obs();
    en_cnt = 0; err_cnt = 0; tx_first_cyc = -1; en_cyc = -1;
    tx_q.delete();
  endtask

  typedef struct {
    int          n;
    logic [31:0] bytes;
    logic [7:0]  a, b;
    logic [3:0]  fun;
    int          en, err;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ma, mb, oa, ob, op, fb;
    logic [15:0] r;
    int          kind, exp_en, exp_err, nb;
    bit          fun_ok;

    vecs[0] = '{2, 32'hDD00_0000, 8'h00, 8'h00, 4'h0, 1, 0, 16'h0000};
    vecs[1] = '{4, 32'hCC05_0300, 8'h05, 8'h03, 4'h0, 1, 0, 16'h0008};
    vecs[2] = '{2, 32'hDD02_0000, 8'h05, 8'h03, 4'h2, 1, 0, 16'h000F};
    vecs[3] = '{1, 32'h7A00_0000, 8'h05, 8'h03, 4'h2, 0, 1, 16'h0000};
    vecs[4] = '{4, 32'hCC10_2008, 8'h10, 8'h20, 4'h8, 1, 0, 16'h0030};
    vecs[5] = '{4, 32'hCC11_221F, 8'h11, 8'h22, 4'h8, 0, 1, 16'h0000};
    vecs[6] = '{2, 32'hDD40_0000, 8'h11, 8'h22, 4'h8, 0, 1, 16'h0000};
    vecs[7] = '{4, 32'hCCFF_FF02, 8'hFF, 8'hFF, 4'h2, 1, 0, 16'hFE01};
    vecs[8] = '{4, 32'hCC07_0901, 8'h07, 8'h09, 4'h1, 1, 0, 16'hFFFE};

    repeat (3) tick();
    check("rst_alu_a", ALU_A, 0);
    check("rst_alu_b", ALU_B, 0);
    check("rst_alu_fun", ALU_FUN, 0);
    check("rst_alu_en", ALU_EN, 0);
    check("rst_tx_vld", TX_D_VLD, 0);
    check("rst_tx_data", TX_P_DATA, 0);
    check("rst_busy", BUSY, 0);
    check("rst_cmd_err", CMD_ERR, 0);
    RST = 1'b0;
    tick();

    // directed frame table
    for (int v = 0; v < 9; v++) begin
      clear_obs();
      alu_lat = 1;
      tx_len  = 2;
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[31 - 8*i -: 8]);
      wait_idle($sformatf("vec%0d", v));
      check($sformatf("vec%0d_en", v), en_cnt, vecs[v].en);
      check($sformatf("vec%0d_err", v), err_cnt, vecs[v].err);
      check($sformatf("vec%0d_ntx", v), tx_q.size(), vecs[v].en ? 2 : 0);
      if (vecs[v].en == 1 && tx_q.size() == 2) begin
        check($sformatf("vec%0d_tx_lo", v), tx_q[0], vecs[v].res[7:0]);
        check($sformatf("vec%0d_tx_hi", v), tx_q[1], vecs[v].res[15:8]);
        check($sformatf("vec%0d_en_lat", v), en_cyc - last_rx_cyc, 1);
        check($sformatf("vec%0d_tx_lat", v), tx_first_cyc - last_rx_cyc, 3);
      end
      check($sformatf("vec%0d_a", v), ALU_A, vecs[v].a);
      check($sformatf("vec%0d_b", v), ALU_B, vecs[v].b);
      check($sformatf("vec%0d_fun", v), ALU_FUN, vecs[v].fun);
    end

    // OUT_VALID exactly TIMEOUT cycles after ALU_EN is still accepted
    clear_obs();
    alu_lat = TIMEOUT;
    send_byte(8'hCC); send_byte(8'h04); send_byte(8'h05); send_byte(8'h00);
    wait_idle("to_edge");
    check("to_edge_err", err_cnt, 0);
    check("to_edge_ntx", tx_q.size(), 2);
    if (tx_q.size() == 2) check("to_edge_tx_lo", tx_q[0], 8'h09);

    // one cycle later is a timeout
    clear_obs();
    alu_lat = TIMEOUT + 1;
    send_byte(8'hDD); send_byte(8'h00);
    wait_idle("to_over");
    check("to_over_en", en_cnt, 1);
    check("to_over_err", err_cnt, 1);
    check("to_over_ntx", tx_q.size(), 0);

    // OUT_VALID and an RX byte together in WAIT_RES
    clear_obs();
    alu_lat = 3;
    send_byte(8'hCC); send_byte(8'h06); send_byte(8'h07); send_byte(8'h02);
    repeat (3) tick();
    send_byte(8'h5A);
    wait_idle("ovl");
    check("ovl_err", err_cnt, 1);
    check("ovl_ntx", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      check("ovl_tx_lo", tx_q[0], 8'h2A);
      check("ovl_tx_hi", tx_q[1], 8'h00);
    end

    // transmitter held busy in SEND_LO, with an overrun byte during the wait
    clear_obs();
    alu_lat = 1;
    alu_force = 1;
    alu_force_val = 16'hABCD;
    force_busy = 1;
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    repeat (4) tick();
    send_byte(8'h77);
    repeat (14) tick();
    check("busy_hold_ntx", tx_q.size(), 0);
    check("busy_hold_busy", BUSY, 1);
    force_busy = 0;
    wait_idle("busy_hold");
    alu_force = 0;
    check("busy_hold_err", err_cnt, 1);
    check("busy_hold_ntx2", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      check("busy_hold_tx_lo", tx_q[0], 8'hCD);
      check("busy_hold_tx_hi", tx_q[1], 8'hAB);
    end
    check("busy_hold_a", ALU_A, 8'h12);

    // reset mid-frame
    clear_obs();
    send_byte(8'hCC); send_byte(8'h01);
    RST = 1'b1;
    tick();
    check("midrst_a", ALU_A, 0);
    check("midrst_b", ALU_B, 0);
    check("midrst_fun", ALU_FUN, 0);
    check("midrst_en", ALU_EN, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_tx_vld", TX_D_VLD, 0);
    check("midrst_err", CMD_ERR, 0);
    RST = 1'b0;
    tick();
    send_byte(8'hCC); send_byte(8'h02); send_byte(8'h02); send_byte(8'h00);
    wait_idle("postrst");
    check("postrst_a", ALU_A, 8'h02);
    check("postrst_ntx", tx_q.size(), 2);
    if (tx_q.size() == 2) check("postrst_tx_lo", tx_q[0], 8'h04);

    // reset while waiting to transmit: nothing is sent afterwards
    clear_obs();
    force_busy = 1;
    send_byte(8'hCC); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
    repeat (5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    force_busy = 0;
    repeat (8) tick();
    check("txrst_ntx", tx_q.size(), 0);
    check("txrst_busy", BUSY, 0);

    // randomized frames against a frame-level reference model
    clear_obs();
    exp_q.delete();
    exp_en = 0; exp_err = 0;
    ma = 8'h00; mb = 8'h00;
    for (int f = 0; f < 40; f++) begin
      kind    = $urandom_range(0, 3);
      alu_lat = $urandom_range(1, TIMEOUT + 1);
      tx_len  = $urandom_range(1, 6);
      oa      = 8'($urandom);
      ob      = 8'($urandom);
      fun_ok  = ($urandom_range(0, 3) != 0);
      fb      = fun_ok ? {4'h0, 4'($urandom)} : {4'($urandom_range(1, 15)), 4'($urandom)};
      if (kind == 3) begin
        op = 8'($urandom);
        while (op == 8'hCC || op == 8'hDD) op = 8'($urandom);
        send_byte(op);
        exp_err++;
      end else begin
        if (kind < 2) begin
          send_byte(8'hCC);
          repeat ($urandom_range(0, 2)) tick();
          send_byte(oa);
          repeat ($urandom_range(0, 2)) tick();
          send_byte(ob);
          ma = oa; mb = ob;
        end else begin
          send_byte(8'hDD);
        end
        repeat ($urandom_range(0, 2)) tick();
        send_byte(fb);
        if (!fun_ok) exp_err++;
        else begin
          exp_en++;
          if (alu_lat > TIMEOUT) exp_err++;
          else begin
            r = ref_alu(ma, mb, fb[3:0]);
            exp_q.push_back(r[7:0]);
            exp_q.push_back(r[15:8]);
          end
        end
      end
      wait_idle("rand");
    end
    check("rand_en", en_cnt, exp_en);
    check("rand_err", err_cnt, exp_err);
    check("rand_ntx", tx_q.size(), exp_q.size());
    nb = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++) check($sformatf("rand_tx%0d", i), tx_q[i], exp_q[i]);
    check("rand_a", ALU_A, ma);
    check("rand_b", ALU_B, mb);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

UART-driven command sequencer for the 16-bit-result ALU. Parses command frames arriving as bytes from the UART receiver and drives the ALU operand, function and enable inputs. Waits for `OUT_VALID` under a timeout, captures the result, and returns it to the UART transmitter as two bytes, low byte first. Sits between the UART RX/TX blocks and the ALU in the control system top level.

## Interface
- `OP_WIDTH`, 8: operand width, equal to the ALU A/B width.
- `RES_WIDTH`, 16: ALU result width; fixed at 2×`OP_WIDTH`.
- `TIMEOUT`, 8: maximum cycles from `ALU_EN` to `OUT_VALID`; range 1..255.
- `CMD_FULL`, 8'hCC: opcode for a full frame: A, B, then FUN.
- `CMD_REUSE`, 8'hDD: opcode for a reuse frame: FUN only, using the stored A and B.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `RX_P_DATA`  in  8  received byte.
- `RX_D_VLD`  in  1  one-cycle pulse; `RX_P_DATA` is valid.
- `ALU_A`, `ALU_B`  out  8 each  registered operands to the ALU.
- `ALU_FUN`  out  4  registered function code.
- `ALU_EN`  out  1  one-cycle ALU enable pulse.
- `ALU_OUT`  in  16  ALU result.
- `OUT_VALID`  in  1  ALU result valid.
- `TX_P_DATA`  out  8  byte to transmit.
- `TX_D_VLD`  out  1  one-cycle transmit request.
- `TX_BUSY`  in  1  transmitter busy. The transmitter registers this signal: it goes high the cycle after an accepted request.
- `BUSY`  out  1  high in every state except IDLE.
- `CMD_ERR`  out  1  one-cycle error pulse.

## Operation
- States: IDLE, GET_A, GET_B, GET_FUN, RUN, WAIT_RES, SEND_LO, GAP, SEND_HI, DONE.
- IDLE, on an RX byte:
  - `CMD_FULL` → GET_A.
  - `CMD_REUSE` → GET_FUN.
  - Any other byte: pulse `CMD_ERR` and stay in IDLE.
- GET_A and GET_B store the next RX byte into the A or B register, then advance.
- GET_FUN, on an RX byte:
  - Upper nibble ≠ 0: pulse `CMD_ERR`, go to IDLE, and keep the A/B registers unchanged. In a full frame they already hold the new values.
  - Otherwise load `ALU_FUN` from the byte and go to RUN.
- RUN: assert `ALU_EN` for exactly one cycle, clear the timeout counter, go to WAIT_RES.
- WAIT_RES:
  - `OUT_VALID` = 1: capture `ALU_OUT` into the result register and go to SEND_LO.
  - Otherwise increment the counter. If the counter reaches `TIMEOUT` first: pulse `CMD_ERR`, go to IDLE, send nothing.
- SEND_LO: when `TX_BUSY` = 0, drive `TX_P_DATA` = res[7:0] and `TX_D_VLD` = 1 for one cycle, then go to GAP.
- GAP: one idle cycle so that `TX_BUSY` can rise.
- SEND_HI: when `TX_BUSY` = 0, issue res[15:8] the same way, then go to DONE.
- DONE: one cycle, then IDLE.
- An RX byte received in any of RUN through DONE is dropped and pulses `CMD_ERR` (overrun).
- After reset, A and B are 0. A reuse frame before any full frame therefore operates on 0,0.
- `ALU_A`, `ALU_B` and `ALU_FUN` hold their values outside RUN/WAIT_RES. They change only on a captured RX byte.

## Timing
- Reset values: all outputs 0, state IDLE, A/B/FUN/result/counter 0.
- `RST` applies at the next edge from any state, including mid-frame or mid-transmit. A partial frame is discarded and no `TX_D_VLD` follows.
- `ALU_EN` is asserted the cycle after the FUN byte is captured, i.e. one cycle in RUN.
- With the nominal 1-cycle ALU (`OUT_VALID` the cycle after `ALU_EN`), the first `TX_D_VLD` comes 3 cycles after the FUN byte's `RX_D_VLD` cycle, given `TX_BUSY` = 0.
- Timeout window:
  - `OUT_VALID` arriving `TIMEOUT` cycles after `ALU_EN` is accepted.
  - At `TIMEOUT`+1 cycles, `CMD_ERR` pulses instead.
- If `OUT_VALID` and an RX byte coincide in WAIT_RES, the result is captured and the byte is dropped with `CMD_ERR`.
- `CMD_ERR` never lasts more than one cycle per event.
- `TX_D_VLD` is never asserted while `TX_BUSY` = 1.

## Structure
- Shared package `alu_ctrl_pkg`: state enumeration, default opcode constants `CMD_FULL`/`CMD_REUSE`, and result byte-order constants.
- One natural sub-module: `alu_timeout_cnt`, a loadable up-counter with a terminal flag, parameterised by `TIMEOUT`.
- Everything else stays in a single FSM plus a datapath register module.

## Test plan
- Full frame: CC, 05, 03, 00. Required: `ALU_A` = 05, `ALU_B` = 03, `ALU_FUN` = 0, one `ALU_EN` pulse. ALU model returns 0008 → TX bytes 08 then 00, `CMD_ERR` never asserted.
- Reuse frame after the above: DD, 02; model returns 000F → TX bytes 0F, 00, and `ALU_A`/`ALU_B` are still 05/03.
- Bad opcode 7A in IDLE → one `CMD_ERR` pulse, no `ALU_EN`. A following CC, 10, 20, 08 then completes normally.
- FUN byte 0x1F → `CMD_ERR`, no `ALU_EN`, return to IDLE. Also: `OUT_VALID` withheld for `TIMEOUT`+1 cycles → `CMD_ERR`, no TX bytes.
- `TX_BUSY` held high for 20 cycles in SEND_LO, with result ABCD → `TX_D_VLD` stays low until `TX_BUSY` falls, then bytes CD, AB. An RX byte during this wait → `CMD_ERR` pulse and the result is still sent.
- `RST` asserted after CC, 01 → next cycle all outputs 0, `BUSY` = 0. The next frame CC, 02, 02, 00 executes with A = 02.
